fir_stream_arbiter: RTL
=======================

// Module: fir_stream_arbiter
//
// PURPOSE
// Shares one fir_15 instance between two AXI-Stream requesters, one packet at a time.
// Round-robin arbitration; the grant is held from a packet's first beat to its tlast beat.
// A tag FIFO records the order of granted packets. The FIR output stream is steered back
// to the matching requester's output port, so two channels run through one filter.
// Sits between the input sources (s00/s01), fir_15 (m00 -> FIR, s02 <- FIR) and the sinks (m01/m02).
//
// PARAMETERS
// C_S00_AXIS_TDATA_WIDTH  32  width of every tdata bus (in, to FIR, from FIR, out)
// TAG_DEPTH               4   max packets granted but not yet returned; power of 2, >=2
//
// PORTS
// s00_axis_aclk                        in   1      single clock for all interfaces
// s00_axis_aresetn                     in   1      reset; asynchronous assert, active-low
// s00_axis_tdata/tvalid/tlast/tready   in/in/in/out   W/1/1/1   requester 0 input stream
// s01_axis_tdata/tvalid/tlast/tready   in/in/in/out   W/1/1/1   requester 1 input stream
// m00_axis_tdata/tvalid/tlast/tready   out/out/out/in W/1/1/1   arbitrated stream to FIR
// s02_axis_tdata/tvalid/tlast/tready   in/in/in/out   W/1/1/1   filtered stream from FIR
// m01_axis_tdata/tvalid/tlast/tready   out/out/out/in W/1/1/1   filtered output, requester 0
// m02_axis_tdata/tvalid/tlast/tready   out/out/out/in W/1/1/1   filtered output, requester 1
// grant                                out  2      one-hot current grant; 2'b00 in IDLE
// inflight                             out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy
//
// BEHAVIOUR
// - Reset (aresetn=0, async): state=IDLE, rr pointer favours requester 0, tag FIFO empty.
//   All tready/tvalid outputs are 0, grant=0, inflight=0, and tdata outputs are 0.
//   A reset during a packet discards that packet and all tags; no recovery is attempted.
// - FSM IDLE -> GRANT0/GRANT1 -> IDLE. All transitions are registered.
//   - IDLE: if inflight<TAG_DEPTH and some sNN_tvalid=1, pick the requester.
//     If both request, pick the one not served last. Push its tag (0/1) into the FIFO and enter GRANTn.
//     If the FIFO is full, stay in IDLE. A pop in the same cycle does not unblock the push;
//     the full check uses the registered count.
//   - GRANTn: m00_tdata/tvalid/tlast = requester n fields, combinationally.
//     sn_tready = m00_tready. The other requester's tready = 0.
//   - On a beat with m00_tvalid & m00_tready & m00_tlast: move to IDLE and update the rr pointer.
//     This costs one bubble cycle per packet.
// - In IDLE, m00_tvalid=0 and both input treadys are 0.
// - Return path, driven by the tag at the FIFO head:
//   - tag 0: m01 = s02 fields, s02_tready = m01_tready, m02_tvalid = 0.
//   - tag 1: the mirror case, using m02.
//   - FIFO empty: s02_tready=0, m01_tvalid=0, m02_tvalid=0.
//   - Pop the head tag on a beat with s02_tvalid & s02_tready & s02_tlast.
//   - Push and pop in the same cycle: inflight is unchanged.
// - The block adds no data latency. The only added delay is the arbitration bubble.
//   Packet boundaries must be preserved by the FIR (tlast is carried through its taps).
// - Every packet is >=1 beat. A single-beat packet (tlast on its first beat) is legal.
// - tdata passes through unmodified. Width rules are the FIR's concern.
// - The return path operates independently of the FSM. Output ordering always equals grant order.
//
// TESTING
// 1. Reset: hold aresetn=0 with inputs valid -> every tvalid/tready=0, grant=0, inflight=0.
//    Deassert -> IDLE.
// 2. Only s00 requests a 3-beat packet (1,2,3; tlast on 3), m00_tready=1 ->
//    grant=01 one cycle after the request; m00 carries 1,2,3; then IDLE.
//    Loop s02=m00 -> m01 emits 1,2,3, m02_tvalid stays 0, and inflight returns to 0.
// 3. Both request continuously with 2-beat packets -> grant order 0,1,0,1.
//    Exactly one IDLE cycle between packets; m01 sees only s00 data and m02 only s01 data.
// 4. TAG_DEPTH=4, s02_tready held low by m01_tready=0, 5 packets offered ->
//    4 granted, inflight=4, FSM stalls in IDLE.
//    Release m01_tready -> the 5th is granted only after the first pop.
// 5. Backpressure: toggle m00_tready 1,0,1,0 mid-packet -> no beat is lost or duplicated;
//    the grant holds until the tlast beat is accepted.
// 6. Assert aresetn=0 mid-packet for 1 cycle -> outputs clear immediately (async).
//    The next packet arbitrates from requester 0 with inflight=0.

Source files
------------

// File: rtl/fir_stream_arbiter.sv
// fir_stream_arbiter: round-robin packet arbiter sharing one FIR between two AXI-Stream
// requesters, with a tag FIFO steering the filtered stream back in grant order.
module fir_stream_arbiter #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s01_axis_tdata,
  input  logic                              s01_axis_tvalid,
  input  logic                              s01_axis_tlast,
  output logic                              s01_axis_tready,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tvalid,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s02_axis_tdata,
  input  logic                              s02_axis_tvalid,
  input  logic                              s02_axis_tlast,
  output logic                              s02_axis_tready,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] m01_axis_tdata,
  output logic                              m01_axis_tvalid,
  output logic                              m01_axis_tlast,
  input  logic                              m01_axis_tready,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] m02_axis_tdata,
  output logic                              m02_axis_tvalid,
  output logic                              m02_axis_tlast,
  input  logic                              m02_axis_tready,
  output logic [1:0]                        grant,
  output logic [$clog2(TAG_DEPTH):0]        inflight
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TAG_DEPTH);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [TAG_DEPTH-1:0] tags_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop, tag, g0, g1, head, empty, sel0, sel1, end_pkt;
  assign g0 = state_q == GRANT0;
  assign g1 = state_q == GRANT1;
  assign grant = {g1, g0};
  assign m00_axis_tdata  = g0 ? s00_axis_tdata : g1 ? s01_axis_tdata : '0;
  assign m00_axis_tvalid = g0 ? s00_axis_tvalid : g1 & s01_axis_tvalid;
  assign m00_axis_tlast  = g0 ? s00_axis_tlast : g1 & s01_axis_tlast;
  assign s00_axis_tready = g0 & m00_axis_tready;
  assign s01_axis_tready = g1 & m00_axis_tready;
  assign end_pkt = m00_axis_tvalid & m00_axis_tready & m00_axis_tlast;
  // last_q records who was served last; reset to 1 so requester 0 wins the first tie
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    push = 1'b0;
    tag = 1'b0;
    if (state_q == IDLE) begin
      if (cnt_q < DEPTH_C && (s00_axis_tvalid || s01_axis_tvalid)) begin
        push = 1'b1;
        tag = (s00_axis_tvalid && s01_axis_tvalid) ? ~last_q : s01_axis_tvalid;
        state_d = tag ? GRANT1 : GRANT0;
      end
    end else if (end_pkt) begin
      state_d = IDLE;
      last_d = g1;
    end
  end
  assign empty = cnt_q == '0;
  assign head = tags_q[rd_q];
  assign sel0 = ~empty & ~head;
  assign sel1 = ~empty & head;
  assign s02_axis_tready = sel0 ? m01_axis_tready : sel1 & m02_axis_tready;
  assign m01_axis_tdata  = sel0 ? s02_axis_tdata : '0;
  assign m01_axis_tvalid = sel0 & s02_axis_tvalid;
  assign m01_axis_tlast  = sel0 & s02_axis_tlast;
  assign m02_axis_tdata  = sel1 ? s02_axis_tdata : '0;
  assign m02_axis_tvalid = sel1 & s02_axis_tvalid;
  assign m02_axis_tlast  = sel1 & s02_axis_tlast;
  assign pop = s02_axis_tvalid & s02_axis_tready & s02_axis_tlast;
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign inflight = cnt_q;
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      tags_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      if (push) begin
        tags_q[wr_q] <= tag;
        wr_q <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end
endmodule
